// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Covers FSM state encoding, parity selectors and line levels.
package uart_tx_fifo_drain_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read side, frame configuration and serial line of the UART transmitter.
interface uart_tx_fifo_drain_if
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W
);

  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  r_inc;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output empty, rd_data, par_en, par_typ,
    input  r_inc, tx_out, busy
  );

  modport slave (
    input  empty, rd_data, par_en, par_typ,
    output r_inc, tx_out, busy
  );

endinterface

// File: rtl/uart_tx_parity.sv
// Combinational parity of one payload word; even or odd selected by par_typ.
module uart_tx_parity
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_c
);

  assign par_c = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining an async FIFO read port: one pop per frame,
// back-to-back frames while data is available, line idle high otherwise.
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_fifo_drain_if.slave  bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_en_q;
  logic                  par_q;
  logic                  tx_out_q;
  logic                  busy_q;
  logic                  r_inc_q;
  logic                  par_fetch_c;
  logic                  fetch_c;

  uart_tx_parity #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (bus.rd_data),
    .par_typ (bus.par_typ),
    .par_c   (par_fetch_c)
  );

  // A new word is taken only at the frame boundaries: from idle or from the stop bit.
  assign fetch_c = !bus.empty && ((state_q == IDLE) || (state_q == STOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_out_q <= IDLE_LVL;
      busy_q   <= 1'b0;
      r_inc_q  <= 1'b0;
    end else begin
      r_inc_q <= 1'b0;
      if (fetch_c) begin
        shift_q  <= bus.rd_data;
        par_en_q <= bus.par_en;
        par_q    <= par_fetch_c;
        r_inc_q  <= 1'b1;
        tx_out_q <= START_LVL;
        busy_q   <= 1'b1;
        state_q  <= START;
      end else begin
        unique case (state_q)
          IDLE: begin
            tx_out_q <= IDLE_LVL;
            busy_q   <= 1'b0;
          end
          START: begin
            tx_out_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
            cnt_q    <= '0;
            state_q  <= DATA;
          end
          DATA: begin
            if (cnt_q == LAST_BIT) begin
              if (par_en_q) begin
                tx_out_q <= par_q;
                state_q  <= PARITY;
              end else begin
                tx_out_q <= IDLE_LVL;
                state_q  <= STOP;
              end
            end else begin
              tx_out_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
              cnt_q    <= cnt_q + CNT_W'(1);
            end
          end
          PARITY: begin
            tx_out_q <= IDLE_LVL;
            state_q  <= STOP;
          end
          STOP: begin
            tx_out_q <= IDLE_LVL;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: begin
            tx_out_q <= IDLE_LVL;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_out = tx_out_q;
  assign bus.busy   = busy_q;
  assign bus.r_inc  = r_inc_q;

endmodule
